uart_receiver: RTL and testbench

Serial-to-parallel UART receiver with 16x oversampling, start-bit validation, optional parity check and framing check. Sits on the RX pin, fed by the shared baud-rate generator's `sample_tick`. Delivers one data word per frame with a single-cycle `rx_done` strobe and per-frame error flags to the downstream FIFO or consumer. It is the receive-side counterpart of `uart_transmitter` and uses the same frame format and tick rate.

---
 rtl/uart_receiver.sv | 143 ++++++++++++++
 tb/tb_uart_receiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled RX with start-bit validation, optional parity and framing check.
// One registered rx_done strobe per completed frame; busy is decoded from the state register.
module uart_receiver #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_TICK  = 16,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [4:0] TickMid  = 5'd7;
  localparam logic [4:0] TickBit  = 5'd15;
  localparam logic [4:0] TickStop = 5'(STOP_TICK - 1);
  localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);

  state_e               state_q;
  logic [4:0]           tick_q;
  logic [2:0]           nbits_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 p_err_q;
  logic                 f_err_q;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 rx_done_q, frame_err_q, parity_err_q;
  logic                 f_err_now;

  // Synchronizer and edge-detect flops reset high so a released reset never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_data;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // With one stop bit the stop sample and the commit land on the same tick.
  assign f_err_now = (tick_q == TickBit) ? ~rx_sync_q : f_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      nbits_q      <= '0;
      shift_q      <= '0;
      p_err_q      <= 1'b0;
      f_err_q      <= 1'b0;
      data_out_q   <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= StStart;
            tick_q  <= '0;
          end
        end
        StStart: begin
          if (sample_tick) begin
            if (tick_q == TickMid) begin
              tick_q  <= '0;
              nbits_q <= '0;
              state_q <= rx_sync_q ? StIdle : StData;
            end else begin
              tick_q <= tick_q + 5'd1;
            end
          end
        end
        StData: begin
          if (sample_tick) begin
            if (tick_q == TickBit) begin
              shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
              tick_q  <= '0;
              if (nbits_q == LastBit) begin
                state_q <= PARITY_EN ? StParity : StStop;
              end else begin
                nbits_q <= nbits_q + 3'd1;
              end
            end else begin
              tick_q <= tick_q + 5'd1;
            end
          end
        end
        StParity: begin
          if (sample_tick) begin
            if (tick_q == TickBit) begin
              p_err_q <= (^shift_q) ^ rx_sync_q ^ PARITY_ODD;
              tick_q  <= '0;
              state_q <= StStop;
            end else begin
              tick_q <= tick_q + 5'd1;
            end
          end
        end
        StStop: begin
          if (sample_tick) begin
            if (tick_q == TickBit) begin
              f_err_q <= ~rx_sync_q;
            end
            if (tick_q == TickStop) begin
              state_q      <= StIdle;
              tick_q       <= '0;
              data_out_q   <= shift_q;
              frame_err_q  <= f_err_now;
              parity_err_q <= PARITY_EN ? p_err_q : 1'b0;
              rx_done_q    <= 1'b1;
            end else begin
              tick_q <= tick_q + 5'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tick_q  <= '0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 8N1, even- and odd-parity instances, 16 clk per sample_tick.
module tb_uart_receiver;

  localparam int BitClk = 256;

  logic clk;
  logic rst_n;
  logic sample_tick;
  logic [3:0] tcnt = 4'd0;
  logic rx_a, rx_p;

  logic [7:0] data_a, data_pe, data_po;
  logic done_a, fe_a, pe_a, busy_a;
  logic done_pe, fe_pe, pe_pe, busy_pe;
  logic done_po, fe_po, pe_po, busy_po;

  int n_vec = 0;
  int n_err = 0;
  int run_a = 0;
  int cnt_pe = 0;
  int cnt_po = 0;
  logic [7:0] q_a[$];

  uart_receiver u_dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_data(rx_a),
    .data_out(data_a), .rx_done(done_a), .frame_err(fe_a), .parity_err(pe_a), .busy(busy_a)
  );

  uart_receiver #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par_even (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_data(rx_p),
    .data_out(data_pe), .rx_done(done_pe), .frame_err(fe_pe), .parity_err(pe_pe),
    .busy(busy_pe)
  );

  uart_receiver #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_par_odd (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_data(rx_p),
    .data_out(data_po), .rx_done(done_po), .frame_err(fe_po), .parity_err(pe_po),
    .busy(busy_po)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tcnt <= tcnt + 4'd1;
  assign sample_tick = (tcnt == 4'd15);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      q_a.push_back(data_a);
      run_a++;
    end else if (run_a != 0) begin
      check("rx_done_width", run_a, 1);
      run_a = 0;
    end
    if (done_pe === 1'b1) cnt_pe++;
    if (done_po === 1'b1) cnt_po++;
  end

  task automatic drive(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_p = v;
  endtask

  task automatic hold_bits(input int n);
    repeat (n * BitClk) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic stop, input int idle_bits);
    drive(which, 1'b0);
    hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      drive(which, d[i]);
      hold_bits(1);
    end
    if (use_par) begin
      drive(which, pbit);
      hold_bits(1);
    end
    drive(which, stop);
    hold_bits(1);
    drive(which, 1'b1);
    hold_bits(idle_bits);
  endtask

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  typedef struct {
    logic [7:0] din;
    logic       pbit;
    logic       exp_even;
    logic       exp_odd;
  } pvec_t;

  vec_t  vecs[7];
  pvec_t pvecs[6];

  initial begin
    logic [7:0] last_d;
    logic [7:0] c3;
    int base_pe, base_po;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 8'h11, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 8'h80, 1'b1};
    vecs[6] = '{8'h01, 1'b1, 8'h01, 1'b0};

    pvecs[0] = '{8'h07, 1'b1, 1'b0, 1'b1};
    pvecs[1] = '{8'h07, 1'b0, 1'b1, 1'b0};
    pvecs[2] = '{8'h00, 1'b0, 1'b0, 1'b1};
    pvecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    pvecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b1};
    pvecs[5] = '{8'h01, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_p  = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("reset_data_out", data_a, 8'h00);
    check("reset_rx_done", done_a, 1'b0);
    check("reset_frame_err", fe_a, 1'b0);
    check("reset_parity_err", pe_a, 1'b0);
    check("reset_busy", busy_a, 1'b0);
    rst_n = 1'b1;
    hold_bits(1);
    check("idle_no_start", busy_a, 1'b0);

    // Main table on the 8N1 instance.
    for (int v = 0; v < 7; v++) begin
      q_a.delete();
      send_frame(0, vecs[v].din, 1'b0, 1'b0, vecs[v].stop, 1);
      check($sformatf("v%0d_done_count", v), q_a.size(), 1);
      check($sformatf("v%0d_data", v), data_a, vecs[v].exp_d);
      check($sformatf("v%0d_frame_err", v), fe_a, vecs[v].exp_fe);
      check($sformatf("v%0d_parity_err", v), pe_a, 1'b0);
      check($sformatf("v%0d_busy", v), busy_a, 1'b0);
    end
    last_d = vecs[6].exp_d;

    // False start: four ticks low, then high again.
    q_a.delete();
    rx_a = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("false_start_busy_hi", busy_a, 1'b1);
    repeat (24) @(posedge clk);
    #1;
    rx_a = 1'b1;
    hold_bits(1);
    check("false_start_busy_lo", busy_a, 1'b0);
    check("false_start_no_done", q_a.size(), 0);
    check("false_start_data_kept", data_a, last_d);

    // Back-to-back frames with no idle gap.
    q_a.delete();
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 0);
    send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1, 1);
    check("b2b_done_count", q_a.size(), 2);
    if (q_a.size() == 2) begin
      check("b2b_first", q_a[0], 8'h55);
      check("b2b_second", q_a[1], 8'hAA);
    end
    check("b2b_frame_err", fe_a, 1'b0);

    // Parity table on both parity instances.
    for (int v = 0; v < 6; v++) begin
      base_pe = cnt_pe;
      base_po = cnt_po;
      send_frame(1, pvecs[v].din, 1'b1, pvecs[v].pbit, 1'b1, 1);
      check($sformatf("p%0d_even_done", v), cnt_pe - base_pe, 1);
      check($sformatf("p%0d_odd_done", v), cnt_po - base_po, 1);
      check($sformatf("p%0d_even_data", v), data_pe, pvecs[v].din);
      check($sformatf("p%0d_even_perr", v), pe_pe, pvecs[v].exp_even);
      check($sformatf("p%0d_odd_perr", v), pe_po, pvecs[v].exp_odd);
      check($sformatf("p%0d_even_ferr", v), fe_pe, 1'b0);
    end

    // Break: line low for three frame times yields exactly one errored 0x00 frame.
    q_a.delete();
    rx_a = 1'b0;
    hold_bits(30);
    check("break_done_during", q_a.size(), 1);
    check("break_data", data_a, 8'h00);
    check("break_frame_err", fe_a, 1'b1);
    check("break_busy", busy_a, 1'b0);
    rx_a = 1'b1;
    hold_bits(2);
    check("break_done_after", q_a.size(), 1);

    // Reset during data bit 4 of 0xC3.
    c3 = 8'hC3;
    q_a.delete();
    rx_a = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 4; i++) begin
      rx_a = c3[i];
      hold_bits(1);
    end
    rx_a = c3[4];
    repeat (BitClk / 2) @(posedge clk);
    #1;
    check("pre_reset_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", busy_a, 1'b0);
    check("mid_reset_data", data_a, 8'h00);
    check("mid_reset_done", done_a, 1'b0);
    check("mid_reset_frame_err", fe_a, 1'b0);
    check("mid_reset_parity_err", pe_a, 1'b0);
    rx_a = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_bits(1);
    check("post_reset_no_done", q_a.size(), 0);
    send_frame(0, c3, 1'b0, 1'b0, 1'b1, 1);
    check("post_reset_done", q_a.size(), 1);
    check("post_reset_data", data_a, 8'hC3);
    check("post_reset_frame_err", fe_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
